// File: rtl/id_scoreboard_bypass.sv
// Decode-stage register scoreboard: per-register pending-write counters plus operand bypass select.
// Operand resolve and waits are combinational; counters update on the rising edge.
module id_scoreboard_bypass #(
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int DW    = 32,
   parameter int NFWD  = 3,
   parameter int CNT_W = 2
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_id_valid,
   input  logic                 i_id_issue,
   input  logic [AW-1:0]        i_rs,
   input  logic [AW-1:0]        i_rt,
   input  logic                 i_rs_used,
   input  logic                 i_rt_used,
   input  logic                 i_id_wen,
   input  logic [AW-1:0]        i_id_wdest,
   input  logic [DW-1:0]        i_rs_rf_value,
   input  logic [DW-1:0]        i_rt_rf_value,
   input  logic [NFWD-1:0]      i_fwd_valid,
   input  logic [NFWD-1:0]      i_fwd_ready,
   input  logic [NFWD*AW-1:0]   i_fwd_dest,
   input  logic [NFWD*DW-1:0]   i_fwd_data,
   input  logic                 i_wb_wen,
   input  logic [AW-1:0]        i_wb_wdest,
   input  logic                 i_flush,
   output logic [DW-1:0]        o_rs_value,
   output logic [DW-1:0]        o_rt_value,
   output logic                 o_rs_wait,
   output logic                 o_rt_wait,
   output logic                 o_full_wait,
   output logic                 o_stall,
   output logic                 o_sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt [NREG];
   logic             r_sb_err;
   logic [DW:0]      w_rs_res;
   logic [DW:0]      w_rt_res;
   logic             w_inc;
   logic             w_dec;
   logic             w_same;
   logic             w_underflow;

   // Result is {wait, value}; the youngest matching port decides, ready or not.
   function automatic logic [DW:0] f_resolve(
      input logic [AW-1:0]      src,
      input logic               used,
      input logic [DW-1:0]      rf,
      input logic               pend,
      input logic [NFWD-1:0]    fv,
      input logic [NFWD-1:0]    fr,
      input logic [NFWD*AW-1:0] fd,
      input logic [NFWD*DW-1:0] fdat
   );
      logic        hit;
      logic [DW:0] res;
      hit = 1'b0;
      res = {1'b0, rf};
      if (!used || src == '0) begin
         res = {1'b0, (src == '0) ? {DW{1'b0}} : rf};
      end else begin
         for (int i = 0; i < NFWD; i++) begin
            if (!hit && fv[i] && fd[i*AW +: AW] == src) begin
               hit = 1'b1;
               res = fr[i] ? {1'b0, fdat[i*DW +: DW]} : {1'b1, rf};
            end
         end
         if (!hit && pend) res = {1'b1, rf};
      end
      return res;
   endfunction

   always_comb begin
      w_rs_res = f_resolve(i_rs, i_rs_used, i_rs_rf_value, r_cnt[i_rs] != '0,
                           i_fwd_valid, i_fwd_ready, i_fwd_dest, i_fwd_data);
      w_rt_res = f_resolve(i_rt, i_rt_used, i_rt_rf_value, r_cnt[i_rt] != '0,
                           i_fwd_valid, i_fwd_ready, i_fwd_dest, i_fwd_data);
   end

   assign o_rs_value  = w_rs_res[DW-1:0];
   assign o_rt_value  = w_rt_res[DW-1:0];
   assign o_rs_wait   = w_rs_res[DW] & ~i_reset;
   assign o_rt_wait   = w_rt_res[DW] & ~i_reset;
   assign o_full_wait = i_id_valid & i_id_wen & (i_id_wdest != '0) &
                        (r_cnt[i_id_wdest] == CNT_MAX) & ~i_reset;
   assign o_stall     = i_id_valid & (o_rs_wait | o_rt_wait | o_full_wait);
   assign o_sb_err    = r_sb_err;

   assign w_inc       = i_id_issue & i_id_wen & (i_id_wdest != '0);
   assign w_dec       = i_wb_wen & (i_wb_wdest != '0);
   assign w_same      = w_inc & w_dec & (i_id_wdest == i_wb_wdest);
   // A retire cancelled by a same-register issue is not an underflow.
   assign w_underflow = w_dec & ~w_same & (r_cnt[i_wb_wdest] == '0);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
         r_sb_err <= 1'b0;
      end else if (i_flush) begin
         for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (w_same && i_id_wdest == AW'(i)) begin
               r_cnt[i] <= r_cnt[i];
            end else if (w_inc && i_id_wdest == AW'(i)) begin
               if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end else if (w_dec && i_wb_wdest == AW'(i)) begin
               if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
         end
         if ((i_id_issue && o_stall) || w_underflow) r_sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_scoreboard_bypass.sv
// Scenario bench for id_scoreboard_bypass: expectations queued at drive time, popped at sample time.
module tb_id_scoreboard_bypass;

   logic        clk;
   logic        rst;
   logic        id_valid, id_issue, rs_used, rt_used, id_wen, wb_wen, flush;
   logic [4:0]  rs, rt, id_wdest, wb_wdest;
   logic [31:0] rs_rf_value, rt_rf_value;
   logic [2:0]  fwd_valid, fwd_ready;
   logic [14:0] fwd_dest;
   logic [95:0] fwd_data;
   logic [31:0] rs_value, rt_value;
   logic        rs_wait, rt_wait, full_wait, stall, sb_err;

   logic [31:0] exp_q[$];
   logic [31:0] e;
   int          checks = 0;
   int          errors = 0;

   id_scoreboard_bypass dut (
      .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .i_id_issue(id_issue),
      .i_rs(rs), .i_rt(rt), .i_rs_used(rs_used), .i_rt_used(rt_used),
      .i_id_wen(id_wen), .i_id_wdest(id_wdest),
      .i_rs_rf_value(rs_rf_value), .i_rt_rf_value(rt_rf_value),
      .i_fwd_valid(fwd_valid), .i_fwd_ready(fwd_ready), .i_fwd_dest(fwd_dest), .i_fwd_data(fwd_data),
      .i_wb_wen(wb_wen), .i_wb_wdest(wb_wdest), .i_flush(flush),
      .o_rs_value(rs_value), .o_rt_value(rt_value), .o_rs_wait(rs_wait), .o_rt_wait(rt_wait),
      .o_full_wait(full_wait), .o_stall(stall), .o_sb_err(sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task set_idle;
      id_valid = 0; id_issue = 0; rs_used = 0; rt_used = 0; id_wen = 0; wb_wen = 0; flush = 0;
      rs = 0; rt = 0; id_wdest = 0; wb_wdest = 0; rs_rf_value = 0; rt_rf_value = 0;
      fwd_valid = 0; fwd_ready = 0; fwd_dest = 0; fwd_data = 0;
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task issue(input logic [4:0] dest);
      set_idle; id_valid = 1; id_issue = 1; id_wen = 1; id_wdest = dest;
      tick;
   endtask

   task retire(input logic [4:0] dest);
      set_idle; wb_wen = 1; wb_wdest = dest;
      tick;
   endtask

   task test_reset;
      set_idle; id_valid = 1; rs_used = 1; rs = 3; rs_rf_value = 32'hAAAA;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL rst_rs_wait: got %0d expected %0d", rs_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL rst_stall: got %0d expected %0d", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL rst_sb_err: got %0d expected %0d", sb_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, full_wait} !== e) begin errors++; $display("FAIL rst_full_wait: got %0d expected %0d", full_wait, e); end
      @(posedge clk); #1 rst = 0;
      exp_q.push_back(32'hAAAA);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL rst_rf_value: got %h expected %h", rs_value, e); end
   endtask

   task test_issue_fwd;
      issue(5'd3);
      set_idle; id_valid = 1; rs_used = 1; rs = 3; rs_rf_value = 32'hDEAD;
      exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL fwd_pending_wait: got %0d expected %0d", rs_wait, e); end
      fwd_valid = 3'b011; fwd_ready = 3'b011; fwd_dest = {5'd0, 5'd3, 5'd3};
      fwd_data = {32'h0, 32'h77, 32'h55};
      exp_q.push_back(32'h55); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL fwd_youngest_value: got %h expected %h", rs_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL fwd_ready_wait: got %0d expected %0d", rs_wait, e); end
      fwd_ready = 3'b010;
      exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL fwd_youngest_not_ready: got %0d expected %0d", rs_wait, e); end
      retire(5'd3);
      set_idle; id_valid = 1; rs_used = 1; rs = 3; rs_rf_value = 32'hDEAD;
      exp_q.push_back(32'hDEAD); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL fwd_after_retire_value: got %h expected %h", rs_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL fwd_after_retire_wait: got %0d expected %0d", rs_wait, e); end
   endtask

   task test_load_use;
      set_idle; id_valid = 1; rt_used = 1; rt = 4; rt_rf_value = 32'h1111;
      fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd4};
      exp_q.push_back(1); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rt_wait} !== e) begin errors++; $display("FAIL load_rt_wait: got %0d expected %0d", rt_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL load_stall: got %0d expected %0d", stall, e); end
      tick;
      fwd_valid = 3'b010; fwd_ready = 3'b010; fwd_dest = {5'd0, 5'd4, 5'd0};
      fwd_data = {32'h0, 32'h1234, 32'h0};
      exp_q.push_back(32'h1234); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rt_value !== e) begin errors++; $display("FAIL load_mem_value: got %h expected %h", rt_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL load_mem_stall: got %0d expected %0d", stall, e); end
   endtask

   task test_untracked;
      issue(5'd5);
      set_idle; id_valid = 1; rs_used = 1; rs = 5; rs_rf_value = 32'h5555;
      exp_q.push_back(1); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL mult_rs_wait: got %0d expected %0d", rs_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL mult_stall: got %0d expected %0d", stall, e); end
      retire(5'd5);
      set_idle; id_valid = 1; rs_used = 1; rs = 5; rs_rf_value = 32'h5555;
      exp_q.push_back(32'h5555); exp_q.push_back(0); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL mult_done_value: got %h expected %h", rs_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL mult_done_wait: got %0d expected %0d", rs_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL mult_sb_err: got %0d expected %0d", sb_err, e); end
   endtask

   task test_saturate;
      for (int k = 0; k < 3; k++) issue(5'd7);
      set_idle; id_valid = 1; id_wen = 1; id_wdest = 7;
      exp_q.push_back(1); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, full_wait} !== e) begin errors++; $display("FAIL sat_full_wait: got %0d expected %0d", full_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL sat_stall: got %0d expected %0d", stall, e); end
      id_issue = 1; wb_wen = 1; wb_wdest = 7;
      tick;
      set_idle; id_valid = 1; id_wen = 1; id_wdest = 7;
      exp_q.push_back(1); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, full_wait} !== e) begin errors++; $display("FAIL sat_issue_retire_cnt: got %0d expected %0d", full_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL sat_illegal_issue_err: got %0d expected %0d", sb_err, e); end
      retire(5'd7);
      retire(5'd7);
      set_idle; id_valid = 1; id_wen = 1; id_wdest = 7; rs_used = 1; rs = 7;
      exp_q.push_back(0); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, full_wait} !== e) begin errors++; $display("FAIL sat_drained_full: got %0d expected %0d", full_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL sat_one_left_wait: got %0d expected %0d", rs_wait, e); end
      retire(5'd7);
      set_idle; rs_used = 1; rs = 7;
      exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL sat_empty_wait: got %0d expected %0d", rs_wait, e); end
      rst = 1;
      exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL sat_reset_err: got %0d expected %0d", sb_err, e); end
      tick;
      rst = 0;
   endtask

   task test_flush;
      issue(5'd2);
      issue(5'd9);
      issue(5'd9);
      set_idle; rs_used = 1; rs = 9;
      exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL flush_pre_wait: got %0d expected %0d", rs_wait, e); end
      set_idle; id_valid = 1; id_issue = 1; id_wen = 1; id_wdest = 2; flush = 1;
      tick;
      set_idle; rs_used = 1; rs = 2; rs_rf_value = 32'h2222; rt_used = 1; rt = 9; rt_rf_value = 32'h9999;
      exp_q.push_back(0); exp_q.push_back(32'h2222); exp_q.push_back(0); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL flush_r2_wait: got %0d expected %0d", rs_wait, e); end
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL flush_r2_value: got %h expected %h", rs_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rt_wait} !== e) begin errors++; $display("FAIL flush_r9_wait: got %0d expected %0d", rt_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL flush_sb_err: got %0d expected %0d", sb_err, e); end
      retire(5'd9);
      set_idle; rs_used = 1; rs = 9;
      exp_q.push_back(1); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL underflow_sb_err: got %0d expected %0d", sb_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL underflow_cnt_wait: got %0d expected %0d", rs_wait, e); end
   endtask

   task test_r0_and_async_reset;
      set_idle; id_valid = 1; rs_used = 1; rs = 0;
      fwd_valid = 3'b001; fwd_ready = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd0};
      fwd_data = {32'h0, 32'h0, 32'hBEEF};
      exp_q.push_back(0); exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if (rs_value !== e) begin errors++; $display("FAIL r0_value: got %h expected %h", rs_value, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL r0_wait: got %0d expected %0d", rs_wait, e); end
      issue(5'd6);
      set_idle; id_valid = 1; rs_used = 1; rs = 6; rt_used = 1; rt = 8;
      fwd_valid = 3'b010; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd8, 5'd0};
      exp_q.push_back(1); exp_q.push_back(1);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL midstall_stall: got %0d expected %0d", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL midstall_err_held: got %0d expected %0d", sb_err, e); end
      rst = 1;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL areset_rs_wait: got %0d expected %0d", rs_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rt_wait} !== e) begin errors++; $display("FAIL areset_rt_wait: got %0d expected %0d", rt_wait, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, stall} !== e) begin errors++; $display("FAIL areset_stall: got %0d expected %0d", stall, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'b0, sb_err} !== e) begin errors++; $display("FAIL areset_sb_err: got %0d expected %0d", sb_err, e); end
      tick;
      rst = 0;
      fwd_valid = 3'b000;
      exp_q.push_back(0);
      #2;
      e = exp_q.pop_front(); checks++;
      if ({31'b0, rs_wait} !== e) begin errors++; $display("FAIL areset_cnt_cleared: got %0d expected %0d", rs_wait, e); end
   endtask

   initial begin
      rst = 1;
      set_idle;
      #2;
      test_reset;
      test_issue_fwd;
      test_load_use;
      test_untracked;
      test_saturate;
      test_flush;
      test_r0_and_async_reset;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
